chunked_adder: RTL

//   Multi-cycle parametrised adder/subtractor. Adds two WIDTH-bit operands CHUNK bits
//   per clock, with a registered carry between chunks. It trades latency for a short

---
 rtl/chunked_adder_if.sv | 27 ++
 rtl/chunked_adder.sv | 94 +++++++++
 2 files changed

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// The producer/consumer side uses master; the adder uses slave.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock.
// A registered carry links the chunks, and the result is held until the consumer accepts it.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  chunked_adder_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CHUNK:0]   sum;
  logic             last, c_msb_in, accept;

  assign sum = {1'b0, a_q[32'(idx_q)*CHUNK +: CHUNK]}
             + {1'b0, b_q[32'(idx_q)*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};
  assign last = (idx_q == IW'(NCH - 1));
  // The MSB result bit equals a^b^carry_in, so the carry into the MSB can be recovered from it.
  assign c_msb_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum[CHUNK-1];

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign accept        = bus.in_ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.x;
          b_d     = bus.sub ? ~bus.y : bus.y;
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[32'(idx_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          cout_d  = sum[CHUNK];
          ovf_d   = c_msb_in ^ sum[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end
endmodule
